// File: rtl/m_keypad_scanner_pkg.sv
// m_keypad_scanner_pkg: shared encodings, sizes and helpers for the keypad scanner.
package m_keypad_scanner_pkg;
  localparam int KEY_W    = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int COL_W    = 2;
  localparam int CNT_W    = 4;
  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;
  typedef enum logic [1:0] {F_NONE, F_KEY, F_MULTI} frame_kind_t;
  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] v);
    logic [2:0] n = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) n = n + 3'(~v[i]);
    return n;
  endfunction
  function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] v);
    logic [1:0] r = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) if (!v[i]) r = 2'(i);
    return r;
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/m_keypad_scanner_frame.sv
// m_keypad_frame: row synchroniser, column prescaler/drive and per-frame result
// accumulation (NONE / KEY / MULTI) reported on the column-3 tick.
module m_keypad_frame
  import m_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [NUM_ROWS-1:0] i_row_n,
  output logic [NUM_COLS-1:0] o_col_n,
  output logic                o_frame_done,
  output frame_kind_t         o_frame_kind,
  output logic [KEY_W-1:0]    o_frame_key
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0]       r_pre;
  logic [COL_W-1:0]    r_col;
  logic [NUM_ROWS-1:0] r_sync1;
  logic [NUM_ROWS-1:0] r_sync2;
  logic [1:0]          r_hits;
  logic [KEY_W-1:0]    r_key;
  logic                w_tick;
  logic                w_done;
  logic [2:0]          w_n;
  logic [1:0]          w_hits;
  logic [KEY_W-1:0]    w_key;
  assign w_tick = r_pre == PW'(SCAN_DIV - 1);
  assign w_done = w_tick && r_col == COL_W'(NUM_COLS - 1);
  assign w_n    = count_low(r_sync2);
  // r_hits saturates at 2: anything beyond one intersection is simply MULTI
  assign w_hits = (w_n > 3'd1 || (w_n == 3'd1 && r_hits != 2'd0)) ? 2'd2 :
                  (w_n == 3'd1) ? 2'd1 : r_hits;
  assign w_key  = (r_hits == 2'd0) ? {low_row(r_sync2), r_col} : r_key;
  assign o_col_n      = ~(NUM_COLS'(1) << r_col);
  assign o_frame_done = w_done;
  assign o_frame_kind = (w_hits == 2'd0) ? F_NONE : (w_hits == 2'd1) ? F_KEY : F_MULTI;
  assign o_frame_key  = w_key;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_pre   <= '0;
      r_col   <= '0;
      r_hits  <= '0;
      r_key   <= '0;
    end else begin
      r_sync1 <= i_row_n;
      r_sync2 <= r_sync1;
      r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_col  <= r_col + 1'b1;
        r_hits <= w_done ? 2'd0 : w_hits;
        r_key  <= w_done ? '0 : w_key;
      end
    end
endmodule

// File: rtl/m_keypad_scanner.sv
// m_keypad_scanner: 4x4 keypad scanner with frame-level debounce and no rollover.
// Optional KEYPAD_REPEAT_EN re-strobes key_valid every REPEAT_FRAMES held frames.
module m_keypad_scanner
  import m_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_FRAMES = 32,
`endif
  parameter int DEB_CNT = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held
);
  state_t           r_state;
  state_t           w_state;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] w_cand;
  logic [CNT_W-1:0] r_match;
  logic [CNT_W-1:0] w_match;
  logic [CNT_W-1:0] r_rel;
  logic [CNT_W-1:0] w_rel;
  logic [KEY_W-1:0] r_code;
  logic [KEY_W-1:0] w_code;
  logic             r_valid;
  logic             w_valid;
  logic             r_held;
  logic             w_held;
  logic             w_done;
  frame_kind_t      w_kind;
  logic [KEY_W-1:0] w_key;
  logic             w_is_cand;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_rep;
`endif
  m_keypad_frame #(.SCAN_DIV(SCAN_DIV)) u_frame (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_row_n      (row_n),
    .o_col_n      (col_n),
    .o_frame_done (w_done),
    .o_frame_kind (w_kind),
    .o_frame_key  (w_key)
  );
  assign w_is_cand = w_kind == F_KEY && w_key == r_cand;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  always_comb begin
    w_state = r_state;
    w_cand  = r_cand;
    w_match = r_match;
    w_rel   = r_rel;
    w_code  = r_code;
    w_valid = 1'b0;
    w_held  = r_held;
    if (w_done)
      case (r_state)
        S_IDLE:
          if (w_kind == F_KEY) begin
            w_cand  = w_key;
            w_match = CNT_W'(1);
            w_state = S_DEBOUNCE;
          end
        S_DEBOUNCE:
          if (w_is_cand) begin
            w_match = sat_inc(r_match);
            if (sat_inc(r_match) >= CNT_W'(DEB_CNT)) begin
              w_code  = r_cand;
              w_valid = 1'b1;
              w_held  = 1'b1;
              w_state = S_PRESSED;
            end
          end else w_state = S_IDLE;
        S_PRESSED:
          if (!w_is_cand) begin
            w_rel   = (w_kind == F_NONE) ? CNT_W'(1) : '0;
            w_state = S_RELEASE;
          end
        S_RELEASE:
          if (w_kind == F_NONE) begin
            w_rel = sat_inc(r_rel);
            if (sat_inc(r_rel) >= CNT_W'(DEB_CNT)) begin
              w_held  = 1'b0;
              w_state = S_IDLE;
            end
          end else if (w_is_cand) w_state = S_PRESSED;
          else w_rel = '0;
        default: w_state = S_IDLE;
      endcase
`ifdef KEYPAD_REPEAT_EN
    // the repeat count only survives frames that stay in PRESSED
    w_rep = (r_state == S_PRESSED && w_state == S_PRESSED) ? r_rep : '0;
    if (r_state == S_PRESSED && w_done && w_is_cand) begin
      w_rep   = (r_rep == RW'(REPEAT_FRAMES - 1)) ? '0 : r_rep + 1'b1;
      w_valid = r_rep == RW'(REPEAT_FRAMES - 1);
    end
`endif
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_match <= '0;
      r_rel   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cand  <= w_cand;
      r_match <= w_match;
      r_rel   <= w_rel;
      r_code  <= w_code;
      r_valid <= w_valid;
      r_held  <= w_held;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= w_rep;
`endif
    end
endmodule
